bulk_out_txn_ctrl: RTL and testbench
====================================

Name: bulk_out_txn_ctrl

Overview:
- Per-endpoint USB bulk OUT transaction sequencer. Sits between the protocol-layer token/packet decoder and the bulk OUT endpoint buffer.
- Decides the handshake for each OUT transaction (ACK/NAK/STALL, optionally NYET) and tracks the DATA0/DATA1 toggle.
- Forwards only accepted payload bytes to the buffer, holding one byte back so that tlast and the CRC-error flag land on the final byte.
- Pulses `xfer_o` for each accepted packet; this feeds the endpoint's re-arm input.

Parameters:
- MAX_PACKET, 512, maximum payload bytes per packet; more than this is babble.
- TIMEOUT, 255, clock cycles allowed from token to data PID before the transaction is abandoned.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- tok_out_i  in  1  one-cycle pulse: OUT token addressed to this endpoint.
- tok_ping_i  in  1  one-cycle pulse: PING token addressed to this endpoint.
- ep_ready_i  in  1  endpoint has room for one MAX_PACKET packet.
- stall_i  in  1  endpoint halted.
- toggle_clr_i  in  1  pulse: reset toggle to DATA0 (SET_CONFIGURATION / CLEAR_FEATURE).
- rx_pid_stb_i  in  1  pulse: DATA PID received.
- rx_pid_data1_i  in  1  PID is DATA1; valid with rx_pid_stb_i.
- rx_tvalid_i  in  1  payload byte valid.
- rx_tready_o  out  1  payload byte accepted.
- rx_tdata_i  in  8  payload byte.
- rx_eop_i  in  1  pulse: end of data packet, after the final byte.
- rx_crc_err_i  in  1  CRC16 bad; valid with rx_eop_i.
- ep_tvalid_o  out  1  byte to endpoint buffer.
- ep_tready_i  in  1  buffer accepts the byte.
- ep_tlast_o  out  1  final byte of the packet.
- ep_tuser_o  out  1  packet corrupt; valid with ep_tlast_o.
- ep_tdata_o  out  8  byte to buffer.
- hsk_tvalid_o  out  1  handshake request.
- hsk_tready_i  in  1  handshake taken by the transmitter.
- hsk_pid_o  out  4  handshake PID: ACK 0010, NAK 1010, STALL 1110, NYET 0110.
- xfer_o  out  1  one-cycle pulse: packet accepted.
- toggle_o  out  1  expected next data PID (0 = DATA0).

Behaviour:
- Reset (async, active-high):
  - State IDLE; toggle_o=0; hold register empty.
  - All outputs 0, except rx_tready_o, which is 1 in IDLE.
- Reset mid-packet: abort immediately. No handshake. No tlast is emitted.
- States:
  - IDLE: rx_tready_o=1; stray bytes are discarded.
  - WAIT_PID.
  - RECV.
  - DROP.
  - DRAIN.
  - HSK.
- IDLE, on tok_out_i:
  - Register stall_i and ep_ready_i, clear the timeout counter, go to WAIT_PID.
  - tok_ping_i is handled per Optional Feature.
- WAIT_PID:
  - Counter increments each cycle. At TIMEOUT → IDLE, no handshake.
  - On rx_pid_stb_i, the decision (priority order) is:
    1. stall → DROP, pending STALL.
    2. !ready → DROP, pending NAK.
    3. PID≠toggle_o → DROP, pending ACK, no toggle flip.
    4. Otherwise → RECV, pending ACK.
- RECV:
  - Hold register 1 byte deep; rx_tready_o = !hold_v | ep_tready_i.
  - An incoming byte pushes the held byte out (ep_tvalid_o=1, ep_tlast_o=0).
  - Byte count is 10 bits. A count exceeding MAX_PACKET sets babble.
  - On rx_eop_i → DRAIN.
- DRAIN:
  - Present the held byte with ep_tlast_o=1 and ep_tuser_o = crc_err|babble, until ep_tready_i.
  - Zero-length packet: no beat is emitted.
  - Then, if crc_err or babble → IDLE with no handshake and no toggle change.
  - Else → HSK with ACK; flip toggle; pulse xfer_o.
- DROP:
  - rx_tready_o=1; bytes are discarded.
  - On rx_eop_i: crc_err → IDLE silently; else → HSK with the pending PID.
- HSK:
  - hsk_tvalid_o=1 with hsk_pid_o held stable until hsk_tready_i.
  - Next state IDLE.
  - Latency is one cycle minimum from eop (DROP) or drain completion.
- Tokens arriving outside IDLE are ignored.
- toggle_clr_i is applied on any cycle. It wins over a same-cycle flip (result DATA0).
- stall_i and ep_ready_i changes mid-transaction have no effect until the next token.
- ep_tvalid_o never deasserts without ep_tready_i once asserted. ep_tdata_o stays stable while stalled.

Optional Feature:
- Macro: BULK_OUT_PING_EN.
- Defined:
  - tok_ping_i in IDLE → HSK directly with STALL if stall_i, ACK if ep_ready_i, else NAK.
  - An accepted OUT is answered NYET instead of ACK if ep_ready_i is low in the cycle DRAIN completes. The toggle still flips and xfer_o still pulses.
- Undefined:
  - tok_ping_i is ignored.
  - NYET (0110) is never generated.

Test Plan:
- Toggle=0, ready=1: OUT, DATA0, bytes 0x11,0x22,0x33, good CRC → ep beats 11,22,33 with tlast on 33, tuser=0; xfer_o one pulse; hsk ACK; toggle_o=1.
- Toggle=1, ready=1: OUT, DATA0 retry (toggle mismatch), 4 bytes → no ep beats, ACK, toggle_o stays 1, no xfer_o.
- ready=0: OUT, DATA1, 8 bytes → no ep beats, NAK; stall_i=1 instead → STALL; toggle unchanged.
- CRC error on 2-byte packet with ep_tready_i toggling 1/0 every cycle → second byte emitted with tlast=1, tuser=1, data stable while stalled; no handshake, toggle unchanged. 513-byte packet → tuser=1, no handshake.
- OUT token then no PID for 255 cycles → IDLE, no handshake. Then a ZLP (DATA0 + eop, no bytes) → no ep beat, ACK, xfer_o pulse. Async reset mid-RECV → all outputs 0, toggle_o=0.
- BULK_OUT_PING_EN: PING with ready=1 → ACK, ready=0 → NAK. Accepted OUT with ep_ready_i falling before DRAIN completes → NYET, toggle flips.

Source files
------------

// File: rtl/bulk_out_txn_ctrl.sv
// Per-endpoint USB bulk OUT transaction sequencer: handshake choice, DATA0/1 toggle, one-byte-delayed payload path.
// Define BULK_OUT_PING_EN to answer PING tokens and to generate NYET on accepted OUT packets.
module bulk_out_txn_ctrl #(
  parameter int MAX_PACKET = 512,
  parameter int TIMEOUT    = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tok_out_i,
  input  logic       tok_ping_i,
  input  logic       ep_ready_i,
  input  logic       stall_i,
  input  logic       toggle_clr_i,
  input  logic       rx_pid_stb_i,
  input  logic       rx_pid_data1_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_eop_i,
  input  logic       rx_crc_err_i,
  output logic       ep_tvalid_o,
  input  logic       ep_tready_i,
  output logic       ep_tlast_o,
  output logic       ep_tuser_o,
  output logic [7:0] ep_tdata_o,
  output logic       hsk_tvalid_o,
  input  logic       hsk_tready_i,
  output logic [3:0] hsk_pid_o,
  output logic       xfer_o,
  output logic       toggle_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [9:0] MAX_CNT = 10'(MAX_PACKET);
  localparam logic [9:0] CNT_SAT = 10'h3ff;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_PID = 3'd1;
  localparam logic [2:0] ST_RECV     = 3'd2;
  localparam logic [2:0] ST_DROP     = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_HSK      = 3'd5;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  logic [2:0]       state;
  logic             toggle;
  logic             stall_r;
  logic             ready_r;
  logic [TMO_W-1:0] tmo_cnt;
  logic             hold_v;
  logic [7:0]       hold_data;
  logic [9:0]       byte_cnt;
  logic             crc_err_r;
  logic [3:0]       hsk_pid_r;
  logic             xfer_r;

  logic       fits;
  logic       babble;
  logic       pkt_bad;
  logic       rx_accept;
  logic       drain_done;
  logic       flip;
  logic [3:0] good_pid;

  // Bytes past MAX_PACKET are swallowed so the held byte stays the last one delivered.
  assign fits       = byte_cnt < MAX_CNT;
  assign babble     = byte_cnt > MAX_CNT;
  assign pkt_bad    = crc_err_r || babble;
  assign rx_accept  = (state == ST_RECV) && rx_tvalid_i && rx_tready_o;
  assign drain_done = (state == ST_DRAIN) && (!hold_v || ep_tready_i);
  assign flip       = drain_done && !pkt_bad;

`ifdef BULK_OUT_PING_EN
  localparam logic [3:0] PID_NYET = 4'b0110;
  logic [3:0] ping_pid;
  assign good_pid = ep_ready_i ? PID_ACK : PID_NYET;
  assign ping_pid = stall_i ? PID_STALL : (ep_ready_i ? PID_ACK : PID_NAK);
`else
  logic unused_ping;
  assign good_pid    = PID_ACK;
  assign unused_ping = tok_ping_i;
`endif

  always_comb begin
    rx_tready_o = 1'b0;
    ep_tvalid_o = 1'b0;
    ep_tlast_o  = 1'b0;
    ep_tuser_o  = 1'b0;
    case (state)
      ST_IDLE, ST_DROP: rx_tready_o = 1'b1;
      ST_RECV: begin
        rx_tready_o = !fits || !hold_v || ep_tready_i;
        ep_tvalid_o = hold_v && fits && rx_tvalid_i;
      end
      ST_DRAIN: begin
        ep_tvalid_o = hold_v;
        ep_tlast_o  = hold_v;
        ep_tuser_o  = hold_v && pkt_bad;
      end
      default: ;
    endcase
  end

  assign ep_tdata_o   = hold_data;
  assign hsk_tvalid_o = (state == ST_HSK);
  assign hsk_pid_o    = (state == ST_HSK) ? hsk_pid_r : 4'b0000;
  assign xfer_o       = xfer_r;
  assign toggle_o     = toggle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      toggle    <= 1'b0;
      stall_r   <= 1'b0;
      ready_r   <= 1'b0;
      tmo_cnt   <= '0;
      hold_v    <= 1'b0;
      hold_data <= 8'h00;
      byte_cnt  <= 10'd0;
      crc_err_r <= 1'b0;
      hsk_pid_r <= 4'b0000;
      xfer_r    <= 1'b0;
    end else begin
      xfer_r <= 1'b0;
      // A clear request beats a same-cycle flip.
      if (toggle_clr_i) begin
        toggle <= 1'b0;
      end else if (flip) begin
        toggle <= ~toggle;
      end

      case (state)
        ST_IDLE: begin
          if (tok_out_i) begin
            stall_r   <= stall_i;
            ready_r   <= ep_ready_i;
            tmo_cnt   <= '0;
            hold_v    <= 1'b0;
            byte_cnt  <= 10'd0;
            crc_err_r <= 1'b0;
            state     <= ST_WAIT_PID;
          end
`ifdef BULK_OUT_PING_EN
          else if (tok_ping_i) begin
            hsk_pid_r <= ping_pid;
            state     <= ST_HSK;
          end
`endif
        end
        ST_WAIT_PID: begin
          if (rx_pid_stb_i) begin
            hsk_pid_r <= PID_ACK;
            if (stall_r) begin
              hsk_pid_r <= PID_STALL;
              state     <= ST_DROP;
            end else if (!ready_r) begin
              hsk_pid_r <= PID_NAK;
              state     <= ST_DROP;
            end else if (rx_pid_data1_i != toggle) begin
              state <= ST_DROP;
            end else begin
              state <= ST_RECV;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (rx_accept) begin
            byte_cnt <= (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 10'd1;
            if (fits) begin
              hold_data <= rx_tdata_i;
              hold_v    <= 1'b1;
            end
          end
          if (rx_eop_i) begin
            crc_err_r <= rx_crc_err_i;
            state     <= ST_DRAIN;
          end
        end
        ST_DROP: begin
          if (rx_eop_i) begin
            state <= rx_crc_err_i ? ST_IDLE : ST_HSK;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            hold_v <= 1'b0;
            if (pkt_bad) begin
              state <= ST_IDLE;
            end else begin
              hsk_pid_r <= good_pid;
              xfer_r    <= 1'b1;
              state     <= ST_HSK;
            end
          end
        end
        ST_HSK: begin
          if (hsk_tready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bulk_out_txn_ctrl.sv
// Randomized self-checking bench for bulk_out_txn_ctrl against a packet-level reference model.
module tb_bulk_out_txn_ctrl;

  localparam int MAX_PACKET = 512;
  localparam int TIMEOUT    = 255;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;
`ifdef BULK_OUT_PING_EN
  localparam bit PING_EN = 1'b1;
`else
  localparam bit PING_EN = 1'b0;
`endif

  logic       clock, reset;
  logic       tok_out_i, tok_ping_i, ep_ready_i, stall_i, toggle_clr_i;
  logic       rx_pid_stb_i, rx_pid_data1_i, rx_tvalid_i, rx_tready_o;
  logic [7:0] rx_tdata_i;
  logic       rx_eop_i, rx_crc_err_i;
  logic       ep_tvalid_o, ep_tready_i, ep_tlast_o, ep_tuser_o;
  logic [7:0] ep_tdata_o;
  logic       hsk_tvalid_o, hsk_tready_i;
  logic [3:0] hsk_pid_o;
  logic       xfer_o, toggle_o;

  bulk_out_txn_ctrl #(.MAX_PACKET(MAX_PACKET), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .tok_out_i(tok_out_i), .tok_ping_i(tok_ping_i), .ep_ready_i(ep_ready_i),
    .stall_i(stall_i), .toggle_clr_i(toggle_clr_i),
    .rx_pid_stb_i(rx_pid_stb_i), .rx_pid_data1_i(rx_pid_data1_i),
    .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o), .rx_tdata_i(rx_tdata_i),
    .rx_eop_i(rx_eop_i), .rx_crc_err_i(rx_crc_err_i),
    .ep_tvalid_o(ep_tvalid_o), .ep_tready_i(ep_tready_i), .ep_tlast_o(ep_tlast_o),
    .ep_tuser_o(ep_tuser_o), .ep_tdata_o(ep_tdata_o),
    .hsk_tvalid_o(hsk_tvalid_o), .hsk_tready_i(hsk_tready_i), .hsk_pid_o(hsk_pid_o),
    .xfer_o(xfer_o), .toggle_o(toggle_o)
  );

  int check_count = 0;
  int fail_count  = 0;

  // ep_mode: 0 random readiness, 1 always ready, 2 alternating every cycle.
  int ep_mode = 1;
  int ep_zero = 0;
  int hsk_zero = 0;

  logic [7:0] tx_bytes[$];
  logic [7:0] obs_data[$];
  bit         obs_last[$];
  bit         obs_user[$];
  logic [3:0] obs_hsk[$];
  int         xfer_seen = 0;
  int         tlast_seen = 0;

  logic [7:0] exp_data[$];
  bit         exp_last[$];
  bit         exp_user[$];
  bit         exp_hsk_valid;
  logic [3:0] exp_pid;
  int         exp_xfer;
  bit         m_toggle = 1'b0;

  bit         ep_wait = 0, hsk_wait = 0;
  logic [7:0] ep_prev_data;
  bit         ep_prev_last, ep_prev_user;
  logic [3:0] hsk_prev_pid;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Readiness of the downstream buffer and the handshake transmitter; random runs never idle more than two cycles.
  initial begin
    ep_tready_i  = 1'b0;
    hsk_tready_i = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ep_mode)
        1: ep_tready_i = 1'b1;
        2: ep_tready_i = !ep_tready_i;
        default: begin
          ep_tready_i = ($urandom % 2 == 1) || (ep_zero >= 2);
          ep_zero = ep_tready_i ? 0 : ep_zero + 1;
        end
      endcase
      hsk_tready_i = ($urandom % 2 == 1) || (hsk_zero >= 2);
      hsk_zero = hsk_tready_i ? 0 : hsk_zero + 1;
    end
  end

  // Observe completed beats and handshakes, and check that stalled outputs hold still.
  always @(negedge clock) begin
    if (reset) begin
      ep_wait  = 0;
      hsk_wait = 0;
    end else begin
      if (ep_wait) begin
        checkOutput("ep_hold_valid", ep_tvalid_o, 1);
        checkOutput("ep_hold_data", ep_tdata_o, ep_prev_data);
        checkOutput("ep_hold_last", ep_tlast_o, ep_prev_last);
        checkOutput("ep_hold_user", ep_tuser_o, ep_prev_user);
      end
      if (hsk_wait) begin
        checkOutput("hsk_hold_valid", hsk_tvalid_o, 1);
        checkOutput("hsk_hold_pid", hsk_pid_o, hsk_prev_pid);
      end
      if (ep_tvalid_o && ep_tready_i) begin
        obs_data.push_back(ep_tdata_o);
        obs_last.push_back(ep_tlast_o);
        obs_user.push_back(ep_tuser_o);
        if (ep_tlast_o) tlast_seen++;
      end
      if (hsk_tvalid_o && hsk_tready_i) obs_hsk.push_back(hsk_pid_o);
      if (xfer_o) xfer_seen++;
      ep_wait      = ep_tvalid_o && !ep_tready_i;
      ep_prev_data = ep_tdata_o;
      ep_prev_last = ep_tlast_o;
      ep_prev_user = ep_tuser_o;
      hsk_wait     = hsk_tvalid_o && !hsk_tready_i;
      hsk_prev_pid = hsk_pid_o;
    end
  end

  task automatic clearObserved();
    obs_data.delete();
    obs_last.delete();
    obs_user.delete();
    obs_hsk.delete();
    xfer_seen = 0;
    exp_data.delete();
    exp_last.delete();
    exp_user.delete();
    exp_hsk_valid = 0;
    exp_pid = 4'b0000;
    exp_xfer = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int cyc = 0;
    bit acc = 0;
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    while (!acc && cyc < 64) begin
      @(negedge clock);
      acc = rx_tready_o;
      tick();
      cyc++;
    end
    rx_tvalid_i = 1'b0;
    if (!acc) checkOutput("rx_accept_timeout", 0, 1);
  endtask

  task automatic compareResults(input string name);
    checkOutput({name, ".beats"}, obs_data.size(), exp_data.size());
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checkOutput({name, ".data"}, obs_data[i], exp_data[i]);
      checkOutput({name, ".last"}, obs_last[i], exp_last[i]);
      checkOutput({name, ".user"}, obs_user[i], exp_user[i]);
    end
    checkOutput({name, ".hsk_count"}, obs_hsk.size(), exp_hsk_valid ? 1 : 0);
    if (obs_hsk.size() == 1 && exp_hsk_valid) checkOutput({name, ".hsk_pid"}, obs_hsk[0], exp_pid);
    checkOutput({name, ".xfer"}, xfer_seen, exp_xfer);
    checkOutput({name, ".toggle"}, toggle_o, m_toggle);
    checkOutput({name, ".idle_ready"}, rx_tready_o, 1);
  endtask

  // One OUT transaction carrying tx_bytes; the expectation is derived from the packet-level rules.
  task automatic applyStimulus(input string name, input bit ready, input bit stall, input bit pid1,
                               input bit crc, input bit ready_late, input bit stall_late,
                               input bit clr_at_end, input int pid_delay);
    int n, keep;
    bit bad;
    clearObserved();
    n    = tx_bytes.size();
    keep = (n < MAX_PACKET) ? n : MAX_PACKET;
    bad  = crc || (n > MAX_PACKET);
    if (pid_delay <= TIMEOUT) begin
      if (stall) begin
        exp_hsk_valid = !crc;
        exp_pid = PID_STALL;
      end else if (!ready) begin
        exp_hsk_valid = !crc;
        exp_pid = PID_NAK;
      end else if (pid1 != m_toggle) begin
        exp_hsk_valid = !crc;
        exp_pid = PID_ACK;
      end else begin
        for (int i = 0; i < keep; i++) begin
          exp_data.push_back(tx_bytes[i]);
          exp_last.push_back(i == keep - 1);
          exp_user.push_back((i == keep - 1) && bad);
        end
        if (!bad) begin
          exp_hsk_valid = 1;
          exp_pid = (PING_EN && !ready_late) ? PID_NYET : PID_ACK;
          exp_xfer = 1;
          m_toggle = !m_toggle;
        end
      end
    end
    if (clr_at_end) m_toggle = 1'b0;

    stall_i = stall;
    ep_ready_i = ready;
    tick();
    tok_out_i = 1'b1;
    tick();
    tok_out_i = 1'b0;
    stall_i = stall_late;
    ep_ready_i = ready_late;
    repeat (pid_delay) tick();
    rx_pid_stb_i = 1'b1;
    rx_pid_data1_i = pid1;
    tick();
    rx_pid_stb_i = 1'b0;
    rx_pid_data1_i = 1'b0;
    foreach (tx_bytes[i]) begin
      if (ep_mode == 0) repeat ($urandom_range(0, 1)) tick();
      sendByte(tx_bytes[i]);
    end
    rx_eop_i = 1'b1;
    rx_crc_err_i = crc;
    tick();
    rx_eop_i = 1'b0;
    rx_crc_err_i = 1'b0;
    if (clr_at_end) begin
      toggle_clr_i = 1'b1;
      tick();
      toggle_clr_i = 1'b0;
    end
    repeat (20) tick();
    compareResults(name);
  endtask

  task automatic applyPing(input string name, input bit ready, input bit stall);
    clearObserved();
    if (PING_EN) begin
      exp_hsk_valid = 1;
      exp_pid = stall ? PID_STALL : (ready ? PID_ACK : PID_NAK);
    end
    stall_i = stall;
    ep_ready_i = ready;
    tick();
    tok_ping_i = 1'b1;
    tick();
    tok_ping_i = 1'b0;
    repeat (12) tick();
    compareResults(name);
  endtask

  task automatic loadBytes(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tlast_before;
    reset = 1'b1;
    tok_out_i = 0; tok_ping_i = 0; ep_ready_i = 0; stall_i = 0; toggle_clr_i = 0;
    rx_pid_stb_i = 0; rx_pid_data1_i = 0; rx_tvalid_i = 0; rx_tdata_i = 8'h00;
    rx_eop_i = 0; rx_crc_err_i = 0;
    #12;
    checkOutput("rst.rx_tready", rx_tready_o, 1);
    checkOutput("rst.ep_tvalid", ep_tvalid_o, 0);
    checkOutput("rst.ep_tlast", ep_tlast_o, 0);
    checkOutput("rst.ep_tuser", ep_tuser_o, 0);
    checkOutput("rst.ep_tdata", ep_tdata_o, 0);
    checkOutput("rst.hsk_tvalid", hsk_tvalid_o, 0);
    checkOutput("rst.hsk_pid", hsk_pid_o, 0);
    checkOutput("rst.xfer", xfer_o, 0);
    checkOutput("rst.toggle", toggle_o, 0);
    #10 reset = 1'b0;
    tick();

    $display("[TB] directed transactions");
    tx_bytes = '{8'h11, 8'h22, 8'h33};
    applyStimulus("good3", 1, 0, 0, 0, 1, 0, 0, 1);
    loadBytes(4);
    applyStimulus("retry", 1, 0, 0, 0, 1, 0, 0, 2);
    loadBytes(8);
    applyStimulus("nak", 0, 0, 1, 0, 1, 1, 0, 0);
    loadBytes(8);
    applyStimulus("stall", 1, 1, 1, 0, 1, 0, 0, 3);

    ep_mode = 2;
    loadBytes(2);
    applyStimulus("crc2", 1, 0, m_toggle, 1, 1, 0, 0, 1);
    ep_mode = 0;
    loadBytes(513);
    applyStimulus("babble", 1, 0, m_toggle, 0, 1, 0, 0, 1);

    ep_mode = 1;
    loadBytes(3);
    applyStimulus("timeout", 1, 0, m_toggle, 0, 1, 0, 0, TIMEOUT + 20);
    loadBytes(3);
    applyStimulus("late_pid", 1, 0, m_toggle, 0, 1, 0, 0, TIMEOUT - 20);
    tx_bytes.delete();
    applyStimulus("zlp", 1, 0, m_toggle, 0, 1, 0, 0, 0);
    loadBytes(5);
    applyStimulus("clr_flip", 1, 0, m_toggle, 0, 1, 0, 1, 0);
    loadBytes(5);
    applyStimulus("nyet", 1, 0, m_toggle, 0, 0, 0, 0, 1);

    applyPing("ping_ack", 1, 0);
    applyPing("ping_nak", 0, 0);
    applyPing("ping_stall", 1, 1);

    $display("[TB] reset mid-packet");
    if (!m_toggle) begin
      loadBytes(2);
      applyStimulus("pre_rst", 1, 0, m_toggle, 0, 1, 0, 0, 0);
    end
    clearObserved();
    tlast_before = tlast_seen;
    stall_i = 0;
    ep_ready_i = 1;
    tok_out_i = 1;
    tick();
    tok_out_i = 0;
    rx_pid_stb_i = 1;
    rx_pid_data1_i = m_toggle;
    tick();
    rx_pid_stb_i = 0;
    rx_pid_data1_i = 0;
    sendByte(8'hA5);
    sendByte(8'h5A);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    m_toggle = 1'b0;
    checkOutput("rstmid.rx_tready", rx_tready_o, 1);
    checkOutput("rstmid.ep_tvalid", ep_tvalid_o, 0);
    checkOutput("rstmid.ep_tlast", ep_tlast_o, 0);
    checkOutput("rstmid.ep_tdata", ep_tdata_o, 0);
    checkOutput("rstmid.hsk_tvalid", hsk_tvalid_o, 0);
    checkOutput("rstmid.xfer", xfer_o, 0);
    checkOutput("rstmid.toggle", toggle_o, 0);
    #10 reset = 1'b0;
    tick();
    rx_eop_i = 1;
    tick();
    rx_eop_i = 0;
    repeat (12) tick();
    checkOutput("rstmid.no_tlast", tlast_seen - tlast_before, 0);
    checkOutput("rstmid.no_hsk", obs_hsk.size(), 0);
    checkOutput("rstmid.toggle_after", toggle_o, m_toggle);

    $display("[TB] randomized transactions");
    ep_mode = 0;
    for (int t = 0; t < 30; t++) begin
      bit r, s, p, c;
      if ($urandom % 8 == 0) begin
        toggle_clr_i = 1;
        tick();
        toggle_clr_i = 0;
        m_toggle = 1'b0;
      end
      r = ($urandom % 4) != 0;
      s = ($urandom % 6) == 0;
      p = (($urandom % 4) == 0) ? !m_toggle : m_toggle;
      c = ($urandom % 6) == 0;
      loadBytes((($urandom % 10) == 0) ? 520 : $urandom_range(0, 16));
      applyStimulus("rand", r, s, p, c, ($urandom % 2) == 1, ($urandom % 2) == 1, 0, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
